// File: rtl/back_propagation_output_layer_vector.sv
// back_propagation_output_layer_vector: serial delta/error computation for the DQN output layer
// through one shared FP32 adder and multiplier, with optional single-action masking.
module adder_floating_point32 #(
    parameter int LAT = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        valid_out,
    output logic [31:0] result
);
    // Denormals flush to zero; round to nearest even on three guard bits.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [26:0] mx, my, sh;
        logic [27:0] s;
        logic [7:0]  d;
        logic [24:0] m;
        int e;
        x = (a[30:0] >= b[30:0]) ? a : b;
        y = (a[30:0] >= b[30:0]) ? b : a;
        mx = (x[30:23] == 8'd0) ? 27'd0 : {1'b1, x[22:0], 3'b000};
        my = (y[30:23] == 8'd0) ? 27'd0 : {1'b1, y[22:0], 3'b000};
        d = x[30:23] - y[30:23];
        sh = (d > 8'd26) ? {26'd0, |my} : (my >> d) | {26'd0, |(my & ((27'd1 << d) - 27'd1))};
        s = (x[31] == y[31]) ? {1'b0, mx} + {1'b0, sh} : {1'b0, mx} - {1'b0, sh};
        e = int'(x[30:23]);
        if (s == 28'd0) return 32'd0;
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e++;
        end
        for (int i = 0; i < 26; i++)
            if (!s[26]) begin
                s = s << 1;
                e--;
            end
        m = {1'b0, s[26:3]} + {24'd0, s[2] & (s[1] | s[0] | s[3])};
        if (m[24]) begin
            m = m >> 1;
            e++;
        end
        if (e <= 0) return 32'd0;
        if (e >= 255) return {x[31], 8'hff, 23'd0};
        return {x[31], e[7:0], m[22:0]};
    endfunction

    logic [LAT-1:0] v;
    logic [31:0]    r [LAT];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < LAT; i++) r[i] <= '0;
        end else begin
            v <= LAT'({v, valid_in});
            r[0] <= fp_add(in_a, in_b);
            for (int i = 1; i < LAT; i++) r[i] <= r[i-1];
        end

    assign valid_out = v[LAT-1];
    assign result    = r[LAT-1];
endmodule

module multiplier_floating_point32 #(
    parameter int LAT = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        valid_out,
    output logic [31:0] result
);
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [24:0] m;
        logic        sg, g, st;
        int e;
        sg = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {sg, 31'd0};
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = {1'b0, p[47:24]};
            g = p[23];
            st = |p[22:0];
            e++;
        end else begin
            m = {1'b0, p[46:23]};
            g = p[22];
            st = |p[21:0];
        end
        m = m + {24'd0, g & (st | m[0])};
        if (m[24]) begin
            m = m >> 1;
            e++;
        end
        if (e <= 0) return {sg, 31'd0};
        if (e >= 255) return {sg, 8'hff, 23'd0};
        return {sg, e[7:0], m[22:0]};
    endfunction

    logic [LAT-1:0] v;
    logic [31:0]    r [LAT];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < LAT; i++) r[i] <= '0;
        end else begin
            v <= LAT'({v, valid_in});
            r[0] <= fp_mul(in_a, in_b);
            for (int i = 1; i < LAT; i++) r[i] <= r[i-1];
        end

    assign valid_out = v[LAT-1];
    assign result    = r[LAT-1];
endmodule

module back_propagation_output_layer_vector #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_OUT    = 3,
    parameter int IDX_WIDTH  = 2,
    parameter int ADD_LAT    = 7,
    parameter int MUL_LAT    = 7
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic                          i_mask_mode,
    input  logic [IDX_WIDTH-1:0]          i_action,
    input  logic [DATA_WIDTH*NUM_OUT-1:0] i_data_node,
    input  logic [DATA_WIDTH*NUM_OUT-1:0] i_data_expected,
    input  logic [DATA_WIDTH*NUM_OUT-1:0] i_data_point,
    output logic                          o_valid,
    output logic [IDX_WIDTH-1:0]          o_index,
    output logic [DATA_WIDTH-1:0]         o_delta_point,
    output logic [DATA_WIDTH-1:0]         o_error_point,
    output logic                          o_last
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2;
    localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NUM_OUT - 1);

    logic [1:0]                    state;
    logic [IDX_WIDTH-1:0]          cnt, action;
    logic                          mask_mode;
    logic [DATA_WIDTH*NUM_OUT-1:0] node, expected, point;
    logic [DATA_WIDTH-1:0]         node_k, exp_k, point_k, sum, prod;
    logic                          add_valid, mul_valid;
    logic [IDX_WIDTH-1:0]          idx_a [ADD_LAT];
    logic [IDX_WIDTH-1:0]          idx_m [MUL_LAT];
    logic                          msk_a [ADD_LAT];
    logic                          msk_m [MUL_LAT];
    logic [DATA_WIDTH-1:0]         dlt_m [MUL_LAT];
    logic                          live;

    assign o_ready = state == IDLE;
    assign node_k  = node[cnt*DATA_WIDTH +: DATA_WIDTH];
    assign exp_k   = expected[cnt*DATA_WIDTH +: DATA_WIDTH];
    assign point_k = point[idx_a[ADD_LAT-1]*DATA_WIDTH +: DATA_WIDTH];
    assign live    = mul_valid && !msk_m[MUL_LAT-1];

    adder_floating_point32 #(.LAT(ADD_LAT)) adder (
        .clk(clk), .rst_n(rst_n), .valid_in(state == ISSUE), .in_a(node_k),
        .in_b({~exp_k[DATA_WIDTH-1], exp_k[DATA_WIDTH-2:0]}), .valid_out(add_valid), .result(sum)
    );

    multiplier_floating_point32 #(.LAT(MUL_LAT)) multiplier (
        .clk(clk), .rst_n(rst_n), .valid_in(add_valid), .in_a(point_k),
        .in_b(sum), .valid_out(mul_valid), .result(prod)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            action    <= '0;
            mask_mode <= 1'b0;
            node      <= '0;
            expected  <= '0;
            point     <= '0;
        end else begin
            case (state)
                IDLE:
                    if (i_valid) begin
                        state     <= ISSUE;
                        cnt       <= '0;
                        action    <= i_action;
                        mask_mode <= i_mask_mode;
                        node      <= i_data_node;
                        expected  <= i_data_expected;
                        point     <= i_data_point;
                    end
                ISSUE: begin
                    cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
                    state <= (cnt == LAST) ? DRAIN : ISSUE;
                end
                DRAIN: state <= o_last ? IDLE : DRAIN;
                default: state <= IDLE;
            endcase
        end

    // Index, mask and delta ride beside the FP pipelines so several channels can be in flight.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < ADD_LAT; i++) begin
                idx_a[i] <= '0;
                msk_a[i] <= 1'b0;
            end
            for (int i = 0; i < MUL_LAT; i++) begin
                idx_m[i] <= '0;
                msk_m[i] <= 1'b0;
                dlt_m[i] <= '0;
            end
        end else begin
            idx_a[0] <= cnt;
            msk_a[0] <= mask_mode && cnt != action;
            for (int i = 1; i < ADD_LAT; i++) begin
                idx_a[i] <= idx_a[i-1];
                msk_a[i] <= msk_a[i-1];
            end
            idx_m[0] <= idx_a[ADD_LAT-1];
            msk_m[0] <= msk_a[ADD_LAT-1];
            dlt_m[0] <= sum;
            for (int i = 1; i < MUL_LAT; i++) begin
                idx_m[i] <= idx_m[i-1];
                msk_m[i] <= msk_m[i-1];
                dlt_m[i] <= dlt_m[i-1];
            end
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            o_valid       <= 1'b0;
            o_last        <= 1'b0;
            o_index       <= '0;
            o_delta_point <= '0;
            o_error_point <= '0;
        end else begin
            o_valid       <= mul_valid;
            o_last        <= mul_valid && idx_m[MUL_LAT-1] == LAST;
            o_index       <= mul_valid ? idx_m[MUL_LAT-1] : '0;
            o_delta_point <= live ? dlt_m[MUL_LAT-1] : '0;
            o_error_point <= live ? prod : '0;
        end
endmodule

// File: tb/tb_back_propagation_output_layer_vector.sv
// tb_back_propagation_output_layer_vector: directed vectors with hand-computed deltas/errors,
// cycle-exact output checks, busy-input handling and mid-flight reset.
module tb_back_propagation_output_layer_vector;
    logic        clk = 1'b0, rst_n = 1'b1;
    logic        i_valid = 1'b0, i_mask_mode = 1'b0;
    logic [1:0]  i_action = 2'd0;
    logic [95:0] i_data_node = '0, i_data_expected = '0, i_data_point = '0;
    logic        o_ready, o_valid, o_last;
    logic [1:0]  o_index;
    logic [31:0] o_delta_point, o_error_point;
    logic [68:0] obs;
    int vectors = 0, miscompares = 0;

    localparam logic [68:0] IDLE_OUT = {1'b1, 68'd0};

    always #5 clk = ~clk;

    back_propagation_output_layer_vector dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_mask_mode(i_mask_mode), .i_action(i_action), .i_data_node(i_data_node),
        .i_data_expected(i_data_expected), .i_data_point(i_data_point), .o_valid(o_valid),
        .o_index(o_index), .o_delta_point(o_delta_point), .o_error_point(o_error_point),
        .o_last(o_last)
    );

    assign obs = {o_ready, o_valid, o_last, o_index, o_delta_point, o_error_point};

    task automatic check(input string tag, input logic [68:0] got, input logic [68:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic m, input logic [1:0] a, input logic [95:0] nd, ex, pt);
        i_valid = 1'b1;
        i_mask_mode = m;
        i_action = a;
        i_data_node = nd;
        i_data_expected = ex;
        i_data_point = pt;
        check("accept_ready", {68'd0, o_ready}, 69'd1);
        step();
        i_valid = 1'b0;
    endtask

    // Checks cycles T+1..T+19 of one sample; returns in T+19 without advancing.
    task automatic watch(input logic [95:0] ed, ee, input bit noise, input string name);
        logic v;
        int k;
        for (int n = 0; n < 19; n++) begin
            v = n >= 15 && n <= 17;
            k = v ? n - 15 : 0;
            check($sformatf("%s_T+%0d", name, n + 1), obs,
                  {n == 18, v, v && k == 2, v ? 2'(k) : 2'd0,
                   v ? ed[k*32 +: 32] : 32'd0, v ? ee[k*32 +: 32] : 32'd0});
            if (n < 18) begin
                if (noise) begin
                    i_valid = 1'b1;
                    i_mask_mode = 1'($urandom);
                    i_action = 2'($urandom);
                    i_data_node = {$urandom, $urandom, $urandom};
                    i_data_expected = {$urandom, $urandom, $urandom};
                    i_data_point = {$urandom, $urandom, $urandom};
                end
                step();
            end
        end
    endtask

    localparam logic [95:0] ND0 = {32'h3F000000, 32'h3F800000, 32'h40000000};
    localparam logic [95:0] EX0 = {32'h3F800000, 32'h3F800000, 32'h3F800000};
    localparam logic [95:0] PT0 = {32'h3F800000, 32'h40000000, 32'h3F000000};
    localparam logic [95:0] ED0 = {32'hBF000000, 32'h00000000, 32'h3F800000};
    localparam logic [95:0] EE0 = {32'hBF000000, 32'h00000000, 32'h3F000000};
    localparam logic [95:0] ND1 = {32'h3F000000, 32'h3FC00000, 32'h40000000};
    localparam logic [95:0] EX1 = {32'h00000000, 32'h3F800000, 32'h00000000};
    localparam logic [95:0] PT1 = {32'h3F800000, 32'h3F800000, 32'h3F800000};
    localparam logic [95:0] ED1 = {32'h00000000, 32'h3F000000, 32'h00000000};
    localparam logic [95:0] ND2 = {32'h3F800000, 32'h40400000, 32'hC0000000};
    localparam logic [95:0] EX2 = {32'h3F800000, 32'h40000000, 32'h3F800000};
    localparam logic [95:0] PT2 = {32'h40800000, 32'hBF800000, 32'h40000000};
    localparam logic [95:0] ED2 = {32'h00000000, 32'h3F800000, 32'hC0400000};
    localparam logic [95:0] EE2 = {32'h00000000, 32'hBF800000, 32'hC0C00000};

    initial begin
        i_valid = 1'b1;
        i_mask_mode = 1'($urandom);
        i_action = 2'($urandom);
        i_data_node = {$urandom, $urandom, $urandom};
        i_data_expected = {$urandom, $urandom, $urandom};
        i_data_point = {$urandom, $urandom, $urandom};
        #1 rst_n = 1'b0;
        #1 check("reset_async", obs, IDLE_OUT);
        step();
        step();
        check("reset_held", obs, IDLE_OUT);
        i_valid = 1'b0;
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            check($sformatf("post_reset_quiet_%0d", n), obs, IDLE_OUT);
            step();
        end

        send(1'b0, 2'd0, ND0, EX0, PT0);
        watch(ED0, EE0, 1'b0, "unmasked");

        send(1'b1, 2'd1, ND1, EX1, PT1);
        watch(ED1, ED1, 1'b0, "mask_a1");

        send(1'b1, 2'd3, ND1, EX1, PT1);
        watch(96'd0, 96'd0, 1'b0, "mask_a3");

        send(1'b0, 2'd0, ND2, EX2, PT2);
        watch(ED2, EE2, 1'b1, "busy_first");
        send(1'b0, 2'd0, ND0, EX0, PT0);
        watch(ED0, EE0, 1'b0, "busy_second");

        step();
        send(1'b0, 2'd0, ND0, EX0, PT0);
        repeat (9) step();
        rst_n = 1'b0;
        #1 check("midflight_reset", obs, IDLE_OUT);
        step();
        step();
        check("midflight_reset_held", obs, IDLE_OUT);
        rst_n = 1'b1;
        for (int n = 0; n < 25; n++) begin
            check($sformatf("aborted_quiet_%0d", n), obs, IDLE_OUT);
            step();
        end
        send(1'b0, 2'd0, ND2, EX2, PT2);
        watch(ED2, EE2, 1'b0, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/back_propagation_output_layer_vector.md
# back_propagation_output_layer_vector

Vector back-propagation stage for the full DQN output layer. It accepts one sample per handshake: node outputs, expected (target) values and per-node derivative points for all `NUM_OUT` actions. It then serially computes `delta = node - expected` and `error = point * delta` for each channel through a single shared FP32 adder and multiplier. In masked (Q-learning) mode only the selected action's channel carries a non-zero TD error. Results stream out one channel per cycle, in index order, to the hidden-layer back-propagation and weight-update blocks.

## Interface
- `DATA_WIDTH`, 32, IEEE-754 single-precision word width
- `NUM_OUT`, 3, number of output nodes (actions), ≥ 2
- `IDX_WIDTH`, 2, channel index width, `≥ clog2(NUM_OUT)`
- `ADD_LAT`, 7, latency of `adder_floating_point32`
- `MUL_LAT`, 7, latency of `multiplier_floating_point32`

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `i_valid`  in  1  sample present
- `o_ready`  out  1  block idle, sample accepted on `i_valid && o_ready`
- `i_mask_mode`  in  1  1: only channel `i_action` is live
- `i_action`  in  `IDX_WIDTH`  taken action (used when mask mode is set)
- `i_data_node`  in  `DATA_WIDTH*NUM_OUT`  node outputs, channel k at `[k*DATA_WIDTH +: DATA_WIDTH]`
- `i_data_expected`  in  `DATA_WIDTH*NUM_OUT`  target values, same packing
- `i_data_point`  in  `DATA_WIDTH*NUM_OUT`  derivative points, same packing
- `o_valid`  out  1  one channel result present
- `o_index`  out  `IDX_WIDTH`  channel of current result
- `o_delta_point`  out  `DATA_WIDTH`  `node - expected`
- `o_error_point`  out  `DATA_WIDTH`  `point * delta`
- `o_last`  out  1  high with the result for channel `NUM_OUT-1`

## Operation
- **Reset:** `o_ready=1`. `o_valid`, `o_last`, `o_index`, `o_delta_point` and `o_error_point` are all 0. The FSM is in IDLE, all pipeline valid/index shift registers are cleared, and the submodules receive `rst_n`.
- **FSM states:**
  - IDLE → ISSUE on accept. All three vectors, `i_mask_mode` and `i_action` are registered.
  - ISSUE: a channel counter runs 0..`NUM_OUT-1`, one channel per cycle into the adder. `inB` is the expected value with its sign bit inverted. → DRAIN after channel `NUM_OUT-1` is issued.
  - DRAIN: waits for `o_last`, then → IDLE.
- **Pipeline alignment:**
  - Channel index and mask bit travel in a shift register alongside the adder.
  - The adder output feeds the multiplier `inB` in the same cycle. The multiplier `inA` is the registered point for that index.
  - Delta is delayed `MUL_LAT` cycles in a shift register, so each delta pairs with its own error.
  - A single holding register is forbidden, because several channels are in flight at once.
- **Mask:**
  - A channel is masked when `i_mask_mode=1` and `index != i_action`.
  - A masked channel still occupies its slot. `o_valid` is asserted and the outputs are forced to exactly `32'h00000000` for both delta and error.
  - If `i_action ≥ NUM_OUT` in mask mode, every channel is masked.
- **Idle outputs:** when `o_valid=0`, outputs are driven to 0 (never z).
- **Inputs while busy:** `i_valid` while `o_ready=0` is ignored. No buffering, no error flag.
- **Arithmetic:** the FP cores are used as-is. No rounding or NaN handling is added here.

## Timing
- Accept cycle is T (`i_valid && o_ready` sampled at edge T). `o_ready` falls at T+1.
- Channel k enters the adder (`valid_in` high) in cycle T+1+k.
- The result for channel k is registered with `o_valid=1` in cycle `T+2+ADD_LAT+MUL_LAT+k`, which is T+16+k at the defaults.
- `o_valid` is contiguous for `NUM_OUT` cycles. `o_last` coincides with the final one.
- `o_ready` returns to 1 the cycle after `o_last`. Minimum sample-to-sample spacing is `NUM_OUT+ADD_LAT+MUL_LAT+2` cycles.
- Reset mid-operation: on assertion of `rst_n`, everything returns to reset values asynchronously. No `o_valid` may appear after release for the aborted sample.

## Test plan
- **Reset:** assert `rst_n=0` with random inputs → all outputs 0, `o_ready=1`. After release, no `o_valid` appears without an accept.
- **Unmasked, defaults:**
  - Stimulus: node={`40000000`,`3F800000`,`3F000000`}, expected={`3F800000`,`3F800000`,`3F800000`}, point={`3F000000`,`40000000`,`3F800000`}.
  - Required: delta={`3F800000`,`00000000`,`BF000000`}, error={`3F000000`,`00000000`,`BF000000`}.
  - `o_valid` at T+16/17/18 with `o_index` 0/1/2, `o_last` at T+18, `o_ready` high at T+19.
- **Masked, action=1:**
  - Stimulus: node={`40000000`,`3FC00000`,`3F000000`}, expected={`00000000`,`3F800000`,`00000000`}, point all `3F800000`.
  - Required: ch0 and ch2 give 0/0, ch1 gives delta=`3F000000`, error=`3F000000`.
- **Masked, action=3 (out of range):** all three channels output delta=error=`00000000`, with three `o_valid` cycles.
- **Busy handling:** hold `i_valid=1` continuously with changing data. The second sample is accepted exactly at T+19, and its results begin at T+35; data presented during T+1..T+18 is ignored.
- **Mid-flight reset:** pulse `rst_n` low at T+10 for 2 cycles → outputs go to 0 immediately and no `o_valid` follows. A new sample accepted afterwards completes with correct values.
